// File: rtl/dividend_reconstructor_if.sv
// Handshake bundle for the dividend reconstructor: operand input channel,
// result output channel and a busy indication.
interface dividend_reconstructor_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     remainder;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic                 rem_err;
    logic                 busy;

    modport master (
        output in_valid, quotient, divisor, remainder, out_ready,
        input  in_ready, out_valid, dividend, rem_err, busy
    );

    modport slave (
        input  in_valid, quotient, divisor, remainder, out_ready,
        output in_ready, out_valid, dividend, rem_err, busy
    );
endinterface

// File: rtl/dividend_reconstructor.sv
// Sequential shift-add multiply-accumulate rebuilding dividend = Q*D + R,
// one partial product per clock, and flagging remainders with R >= D.
module dividend_reconstructor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    dividend_reconstructor_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     div_q;
    logic [WIDTH:0]       acc_hi_q;
    logic [WIDTH-1:0]     acc_lo_q;
    logic [CntW-1:0]      cnt_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 rem_err_q;
    logic [2*WIDTH-1:0]   dividend_q;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     shifted;

    // Carry of the partial-product add lands in sum[WIDTH] and shifts down next step.
    always_comb begin
        sum     = acc_hi_q + (acc_lo_q[0] ? {1'b0, div_q} : {(WIDTH+1){1'b0}});
        shifted = {sum, acc_lo_q} >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rem_err_q   <= 1'b0;
            dividend_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        div_q      <= bus.divisor;
                        acc_hi_q   <= {1'b0, bus.remainder};
                        acc_lo_q   <= bus.quotient;
                        rem_err_q  <= (bus.remainder >= bus.divisor);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StMul;
                    end
                end
                StMul: begin
                    acc_hi_q <= shifted[2*WIDTH:WIDTH];
                    acc_lo_q <= shifted[WIDTH-1:0];
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        dividend_q  <= shifted[2*WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.rem_err   = rem_err_q;
    assign bus.dividend  = dividend_q;
endmodule

// File: tb/tb_dividend_reconstructor.sv
// Directed and random self-checking bench for dividend_reconstructor (WIDTH=8).
module tb_dividend_reconstructor;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dividend_reconstructor_if #(.WIDTH(WIDTH)) bus ();

    dividend_reconstructor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one edge; assumes in_ready is high.
    task automatic start_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r);
        bus.quotient  = q;
        bus.divisor   = d;
        bus.remainder = r;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    // Returns the index of the first edge (accept edge = 0) that sees out_valid high.
    task automatic wait_done(output int edge_idx, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) timed_out = 1'b1;
        edge_idx = n + 1;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.dividend, bus.rem_err, bus.busy} !==
            {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b div=%0d err=%b busy=%b, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.dividend, bus.rem_err, bus.busy);
        end
    endtask

    task automatic test_basic();
        int e;
        bit to;
        start_op(8'd13, 8'd10, 8'd7);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: got busy=%b rdy=%b, want 1 0", bus.busy, bus.in_ready);
        end
        wait_done(e, to);
        n_checks++;
        if (to || e != 9) begin
            n_fail++;
            $display("FAIL basic_latency: got edge %0d (timeout=%0b), want 9", e, to);
        end
        n_checks++;
        if (bus.dividend !== 16'd137 || bus.rem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got %0d err=%b, want 137 err=0", bus.dividend, bus.rem_err);
        end
        handshake();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got rdy=%b vld=%b busy=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_max();
        int e;
        bit to;
        start_op(8'd255, 8'd255, 8'd254);
        wait_done(e, to);
        n_checks++;
        if (to || bus.dividend !== 16'd65279 || bus.rem_err !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL max_carry: got %0d err=%b busy=%b to=%0b, want 65279 err=0 busy=1",
                     bus.dividend, bus.rem_err, bus.busy, to);
        end
        handshake();
    endtask

    task automatic test_rem_err();
        int e;
        bit to;
        start_op(8'd5, 8'd0, 8'd3);
        wait_done(e, to);
        n_checks++;
        if (to || bus.dividend !== 16'd3 || bus.rem_err !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero: got %0d err=%b to=%0b, want 3 err=1", bus.dividend, bus.rem_err, to);
        end
        handshake();
        start_op(8'd4, 8'd6, 8'd6);
        wait_done(e, to);
        n_checks++;
        if (to || bus.dividend !== 16'd30 || bus.rem_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rem_eq_div: got %0d err=%b to=%0b, want 30 err=1", bus.dividend, bus.rem_err, to);
        end
        handshake();
        start_op(8'd0, 8'd9, 8'd8);
        wait_done(e, to);
        n_checks++;
        if (to || e != 9 || bus.dividend !== 16'd8 || bus.rem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL q_zero: got %0d err=%b edge=%0d, want 8 err=0 edge=9",
                     bus.dividend, bus.rem_err, e);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int e;
        bit to;
        start_op(8'd20, 8'd11, 8'd5);
        wait_done(e, to);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.dividend !== 16'd225 || bus.rem_err !== 1'b0 ||
                bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: got vld=%b div=%0d err=%b rdy=%b, want 1 225 0 0",
                         i, bus.out_valid, bus.dividend, bus.rem_err, bus.in_ready);
            end
        end
        handshake();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: got rdy=%b vld=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        bit to;
        bus.out_ready = 1'b1;
        start_op(8'd100, 8'd100, 8'd5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: got vld=%b rdy=%b busy=%b, want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        bus.out_ready = 1'b0;
        start_op(8'd2, 8'd3, 8'd1);
        wait_done(e, to);
        n_checks++;
        if (to || bus.dividend !== 16'd7 || bus.rem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_abort: got %0d err=%b to=%0b, want 7 err=0", bus.dividend, bus.rem_err, to);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int e;
        bit to;
        bus.quotient  = 8'd7;
        bus.divisor   = 8'd9;
        bus.remainder = 8'd2;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.quotient  = 8'd11;
        bus.divisor   = 8'd12;
        bus.remainder = 8'd13;
        wait_done(e, to);
        n_checks++;
        if (to || bus.dividend !== 16'd65 || bus.rem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d err=%b to=%0b, want 65 err=0", bus.dividend, bus.rem_err, to);
        end
        handshake();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got rdy=%b busy=%b, want 1 0", bus.in_ready, bus.busy);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got rdy=%b busy=%b, want 0 1", bus.in_ready, bus.busy);
        end
        wait_done(e, to);
        n_checks++;
        if (to || bus.dividend !== 16'd145 || bus.rem_err !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d err=%b to=%0b, want 145 err=1", bus.dividend, bus.rem_err, to);
        end
        handshake();
    endtask

    task automatic test_random();
        int e;
        bit to;
        logic [7:0]  q, d, r;
        logic [15:0] exp_div;
        for (int i = 0; i < 1000; i++) begin
            q = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            exp_div = 16'(q) * 16'(d) + 16'(r);
            start_op(q, d, r);
            wait_done(e, to);
            n_checks++;
            if (to || bus.dividend !== exp_div || bus.rem_err !== (r >= d)) begin
                n_fail++;
                $display("FAIL rand_%0d: q=%0d d=%0d r=%0d got %0d err=%b, want %0d err=%b",
                         i, q, d, r, bus.dividend, bus.rem_err, exp_div, (r >= d));
            end
            handshake();
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.quotient  = '0;
        bus.divisor   = '0;
        bus.remainder = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_rem_err();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
